if_id_stage_reg: RTL and testbench

IF/ID pipeline register of the 5-stage MIPS pipeline; captures fetched instruction and PC+4 and presents decoded rs/rt/rd fields to the ID stage (ID forwarding unit, register file, hazard unit).
Handles hazard stalls, taken-branch/jump flushes, debug-unit gating and HALT detection, which freezes the front end.
Sits directly upstream of the ID-stage forwarding and hazard logic.

---
 rtl/if_id_stage_reg_if.sv | 41 ++++
 rtl/if_id_stage_reg.sv | 92 +++++++++
 tb/tb_if_id_stage_reg.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/if_id_stage_reg_if.sv
// IF/ID stage register bus: IF-side inputs and ID-side registered outputs.
// Optional perf counter outputs appear when IF_ID_PERF_CNT_EN is defined.
interface if_id_stage_reg_if #(
  parameter int unsigned DATA_W = 32
);
  logic              i_enable;
  logic              i_stall;
  logic              i_flush;
  logic [DATA_W-1:0] i_pc_plus4;
  logic [DATA_W-1:0] i_instr;
  logic              i_instr_valid;
  logic [DATA_W-1:0] o_pc_plus4;
  logic [DATA_W-1:0] o_instr;
  logic              o_valid;
  logic [4:0]        o_rs;
  logic [4:0]        o_rt;
  logic [4:0]        o_rd;
  logic              o_halted;
`ifdef IF_ID_PERF_CNT_EN
  logic [15:0]       o_stall_cnt;
  logic [15:0]       o_flush_cnt;
`endif

  // Upstream side: fetch unit, hazard unit and debug unit drive the controls.
  modport master (
    output i_enable, i_stall, i_flush, i_pc_plus4, i_instr, i_instr_valid,
    input  o_pc_plus4, o_instr, o_valid, o_rs, o_rt, o_rd, o_halted
`ifdef IF_ID_PERF_CNT_EN
    , input o_stall_cnt, o_flush_cnt
`endif
  );

  // Stage register side.
  modport slave (
    input  i_enable, i_stall, i_flush, i_pc_plus4, i_instr, i_instr_valid,
    output o_pc_plus4, o_instr, o_valid, o_rs, o_rt, o_rd, o_halted
`ifdef IF_ID_PERF_CNT_EN
    , output o_stall_cnt, o_flush_cnt
`endif
  );
endinterface

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register for the 5-stage MIPS pipeline.
// Handles stall hold, flush bubbles, debug enable gating and HALT freeze.
// Optional macro IF_ID_PERF_CNT_EN adds saturating stall/flush counters.
module if_id_stage_reg #(
  parameter int unsigned DATA_W      = 32,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input logic              clk,
  input logic              reset,
  if_id_stage_reg_if.slave bus
);

  localparam int unsigned OPC_MSB = DATA_W - 1;
  localparam int unsigned OPC_LSB = DATA_W - 6;

  logic [DATA_W-1:0] pc_plus4_q;
  logic [DATA_W-1:0] instr_q;
  logic              valid_q;
  logic              halted_q;

  logic hold_path;
  logic stall_path;
  logic bubble_path;
  logic is_halt;

  // Path decode in priority order: halted > disabled > stall > flush > load.
  assign hold_path   = halted_q || !bus.i_enable;
  assign stall_path  = !hold_path && bus.i_stall;
  assign bubble_path = !hold_path && !bus.i_stall && bus.i_flush;
  assign is_halt     = bus.i_instr_valid && (bus.i_instr[OPC_MSB:OPC_LSB] == HALT_OPCODE);

  // Pipeline register update; HALT is captured as a real instruction so it drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_plus4_q <= '0;
      instr_q    <= DATA_W'(NOP_INSTR);
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else if (hold_path || stall_path) begin
      pc_plus4_q <= pc_plus4_q;
    end else if (bubble_path) begin
      pc_plus4_q <= '0;
      instr_q    <= DATA_W'(NOP_INSTR);
      valid_q    <= 1'b0;
    end else begin
      pc_plus4_q <= bus.i_pc_plus4;
      if (bus.i_instr_valid) begin
        instr_q <= bus.i_instr;
        valid_q <= 1'b1;
      end else begin
        instr_q <= DATA_W'(NOP_INSTR);
        valid_q <= 1'b0;
      end
      if (is_halt) begin
        halted_q <= 1'b1;
      end
    end
  end

  assign bus.o_pc_plus4 = pc_plus4_q;
  assign bus.o_instr    = instr_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_halted   = halted_q;
  assign bus.o_rs       = instr_q[25:21];
  assign bus.o_rt       = instr_q[20:16];
  assign bus.o_rd       = instr_q[15:11];

`ifdef IF_ID_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // Saturating event counters; frozen while halted or disabled by path decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall_path && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (bubble_path && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

  assign bus.o_stall_cnt = stall_cnt;
  assign bus.o_flush_cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Directed self-checking bench for if_id_stage_reg.
module tb_if_id_stage_reg;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  if_id_stage_reg_if #(.DATA_W(32)) bus ();

  if_id_stage_reg #(
    .DATA_W     (32),
    .NOP_INSTR  (32'h0000_0000),
    .HALT_OPCODE(6'b111111)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic st, input logic fl,
                       input logic [31:0] pc, input logic [31:0] ins, input logic v);
    bus.i_enable      = en;
    bus.i_stall       = st;
    bus.i_flush       = fl;
    bus.i_pc_plus4    = pc;
    bus.i_instr       = ins;
    bus.i_instr_valid = v;
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                             input logic v, input logic h);
    check({tag, "_pc"},     bus.o_pc_plus4, pc);
    check({tag, "_instr"},  bus.o_instr, ins);
    check({tag, "_valid"},  32'(bus.o_valid), 32'(v));
    check({tag, "_halted"}, 32'(bus.o_halted), 32'(h));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    step();
    check_state("reset", 32'h0, 32'h0, 1'b0, 1'b0);
    check("reset_rs", 32'(bus.o_rs), 32'd0);
    reset = 1'b0;

    // add $8,$9,$10
    drive(1'b1, 1'b0, 1'b0, 32'h4, 32'h012A4020, 1'b1);
    step();
    check_state("add", 32'h4, 32'h012A4020, 1'b1, 1'b0);
    check("add_rs", 32'(bus.o_rs), 32'd9);
    check("add_rt", 32'(bus.o_rt), 32'd10);
    check("add_rd", 32'(bus.o_rd), 32'd8);

    // Load then two stall cycles, then capture.
    drive(1'b1, 1'b0, 1'b0, 32'h8, 32'h8D090004, 1'b1);
    step();
    check_state("lw", 32'h8, 32'h8D090004, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'hC, 32'h11111111, 1'b1);
    step();
    check_state("stall1", 32'h8, 32'h8D090004, 1'b1, 1'b0);
    step();
    check_state("stall2", 32'h8, 32'h8D090004, 1'b1, 1'b0);
    bus.i_stall = 1'b0;
    step();
    check_state("post_stall", 32'hC, 32'h11111111, 1'b1, 1'b0);

    // Flush inserts a bubble.
    drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h22222222, 1'b1);
    step();
    check_state("flush", 32'h0, 32'h0, 1'b0, 1'b0);
    check("flush_rs", 32'(bus.o_rs), 32'd0);
    check("flush_rt", 32'(bus.o_rt), 32'd0);
    check("flush_rd", 32'(bus.o_rd), 32'd0);

    // Stall beats flush.
    drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h33333333, 1'b1);
    step();
    drive(1'b1, 1'b1, 1'b1, 32'h14, 32'h44444444, 1'b1);
    step();
    check_state("stall_flush", 32'h10, 32'h33333333, 1'b1, 1'b0);

    // Disabled: flush and new inputs ignored for three cycles.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h100 + 32'(i), 32'hA0000000 + 32'(i), 1'b1);
      step();
      check_state("disabled", 32'h10, 32'h33333333, 1'b1, 1'b0);
    end

    // Invalid fetch loads NOP but updates PC+4.
    drive(1'b1, 1'b0, 1'b0, 32'h14, 32'h55555555, 1'b0);
    step();
    check_state("invalid", 32'h14, 32'h0, 1'b0, 1'b0);

    // HALT opcode on an invalid fetch must not halt.
    drive(1'b1, 1'b0, 1'b0, 32'h18, 32'hFC000000, 1'b0);
    step();
    check_state("halt_invalid", 32'h18, 32'h0, 1'b0, 1'b0);

    // HALT captured on the same edge, then frozen.
    drive(1'b1, 1'b0, 1'b0, 32'h1C, 32'hFC000000, 1'b1);
    step();
    check_state("halt", 32'h1C, 32'hFC000000, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 32'h20, 32'h66666666, 1'b1);
    step();
    check_state("halt_flush", 32'h1C, 32'hFC000000, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h24, 32'h77777777, 1'b1);
    step();
    check_state("halt_load", 32'h1C, 32'hFC000000, 1'b1, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_state("halt_reset", 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset while stalled clears everything.
    drive(1'b1, 1'b0, 1'b0, 32'h28, 32'h012A4020, 1'b1);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h2C, 32'h88888888, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_state("stall_reset", 32'h0, 32'h0, 1'b0, 1'b0);

`ifdef IF_ID_PERF_CNT_EN
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    reset = 1'b0;
    check("cnt_reset_stall", 32'(bus.o_stall_cnt), 32'd0);
    check("cnt_reset_flush", 32'(bus.o_flush_cnt), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h1, 1'b1);
    repeat (3) step();
    drive(1'b1, 1'b0, 1'b1, 32'h4, 32'h1, 1'b1);
    repeat (2) step();
    drive(1'b0, 1'b1, 1'b1, 32'h4, 32'h1, 1'b1);
    step();
    check("cnt_stall", 32'(bus.o_stall_cnt), 32'd3);
    check("cnt_flush", 32'(bus.o_flush_cnt), 32'd2);
    force dut.stall_cnt = 16'hFFFF;
    #1;
    release dut.stall_cnt;
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h1, 1'b1);
    step();
    check("cnt_sat", 32'(bus.o_stall_cnt), 32'h0000FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
